mc_datapath_seq: RTL and testbench
==================================

Name: mc_datapath_seq

Overview:
- Multi-cycle successor to the single-cycle KGP-RISC datapath, parametrised in data width, memory address widths and memory read latency.
- Owns PC, IR, ALU-result, MDR and link registers, plus the instruction-phase FSM.
- Drives instruction and data BRAM ports with correct registered-read timing.
- The external control unit, ALU, register file and branch unit connect combinationally around it.

Parameters:
XLEN, 32, datapath width (≥16)
IMEM_AW, 10, instruction memory word-address width
DMEM_AW, 10, data memory word-address width
MEM_LAT, 1, BRAM read latency in cycles (1..4), applies to both memories
RESET_PC, 0, PC value loaded on reset (byte address, multiple of 4)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
run  in  1  1 = execute; 0 = park in IDLE at the next instruction boundary
imem_addr  out  IMEM_AW  instruction word address = pc[IMEM_AW+1:2]
imem_rdata  in  32  instruction memory read data
ir  out  32  latched instruction
opcode  out  5  ir[31:27]
funccode  out  5  ir[4:0]
is_load, is_store, reg_write, link, is_halt  in  1 each  control-unit decode of ir
alu_res  in  XLEN  external ALU result (effective address for load/store)
br_taken  in  1  branch resolved taken (valid in EXEC)
br_target  in  XLEN  branch target byte address
st_data  in  XLEN  store data from register file
dmem_addr  out  DMEM_AW  alu_q[DMEM_AW+1:2]
dmem_wdata  out  XLEN  latched store data
dmem_we  out  1  data memory write strobe
dmem_rdata  in  XLEN  data memory read data
wb_en  out  1  register-file write enable pulse
wb_data  out  XLEN  write-back value
pc  out  XLEN  current PC
state  out  3  FSM state encoding, debug
retire  out  1  one-cycle pulse per completed instruction
halted  out  1  high in HALT

Behaviour:
- Reset: state=IDLE, pc=RESET_PC. ir, alu_q, mdr, dmem_wdata all 0. dmem_we, wb_en, retire, halted all 0. Reset asserted mid-instruction aborts it; no write-back or store completes in the reset cycle.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: imem_addr driven from pc. Go to FETCH when run=1.
- FETCH: imem_addr=pc held. A wait counter runs MEM_LAT cycles. On the last cycle, ir<=imem_rdata, then go to DECODE.
- DECODE: 1 cycle for control decode and regfile read.
  - If is_halt, go to HALT with pc unchanged.
  - Otherwise go to EXEC.
- EXEC: 1 cycle.
  - Latch alu_q<=alu_res, dmem_wdata<=st_data, taken_q<=br_taken, tgt_q<=br_target.
  - If is_load or is_store, go to MEM. Else if reg_write, go to WB. Else retire.
- MEM:
  - Store: dmem_we=1 for exactly the first MEM cycle, then retire.
  - Load: wait MEM_LAT cycles, mdr<=dmem_rdata on the last cycle, then go to WB.
  - is_load and is_store both set: treated as load, no write.
- WB: wb_en=1 for exactly one cycle, then retire.
  - wb_data = mdr if is_load; else pc+4 if link; else alu_q.
- Retire (transition out of MEM, EXEC or WB):
  - retire=1 for one cycle.
  - pc <= taken_q ? tgt_q : pc+4 (modulo 2^XLEN, wraps silently).
  - Next state is FETCH if run=1, else IDLE.
- HALT: sticky until rst. halted=1, all strobes 0.
- Latency per instruction:
  - ALU / link: MEM_LAT+3 cycles.
  - Store: MEM_LAT+3 cycles.
  - Load: 2*MEM_LAT+3 cycles.
  - Non-link branch: MEM_LAT+2 cycles.
- Control inputs are sampled only in DECODE/EXEC/MEM/WB; changes elsewhere are ignored.
- run=0 never interrupts an in-flight instruction.

Decomposition:
- Shared package kgp_risc_pkg holds:
  - the state enum and its 3-bit encoding;
  - the IR field slice constants: OPC_MSB/LSB=31/27, FUNC_MSB/LSB=4/0, RS=26:22, RT=21:17.
- One sub-module: mem_wait_cnt, a load/decrement counter of width clog2(MEM_LAT)+1 with a done flag. It is instantiated once and shared by FETCH and MEM, since they never overlap.

Test Plan:
- MEM_LAT=1, RESET_PC=0, run=1, ALU op with reg_write=1, alu_res=0x1234 -> wb_en=1 with wb_data=0x1234 in cycle 4 after reset release; retire=1 in the same cycle; pc=4 on the next cycle.
- MEM_LAT=3, load at pc=8, alu_res=0x40, dmem_rdata=0xDEADBEEF -> dmem_addr=0x10; wb_data=0xDEADBEEF; 9 cycles total; pc=12 afterwards.
- Store with st_data=0xA5A5, alu_res=0x20 -> dmem_we high exactly 1 cycle with dmem_addr=8 and dmem_wdata=0xA5A5; wb_en never asserted.
- Taken link branch at pc=0x100, br_target=0x200, link=1, reg_write=1 -> wb_data=0x104; pc=0x200 after retire.
- run dropped mid-load -> load completes and write-back occurs; FSM then parks in IDLE with pc advanced; reasserting run resumes fetch at the new pc.
- is_halt in DECODE -> HALT, halted=1, pc frozen. Reset asserted during a MEM store wait cycle (MEM_LAT=2) -> state=IDLE, pc=RESET_PC, dmem_we stays 0.

Source files
------------

// File: rtl/kgp_risc_pkg.sv
// Shared definitions for the multi-cycle KGP-RISC datapath: FSM state encoding and IR field slices.
package kgp_risc_pkg;

  // Instruction-phase FSM; the 3-bit encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  // IR field positions.
  localparam int unsigned OPC_MSB  = 31;
  localparam int unsigned OPC_LSB  = 27;
  localparam int unsigned FUNC_MSB = 4;
  localparam int unsigned FUNC_LSB = 0;
  localparam int unsigned RS_MSB   = 26;
  localparam int unsigned RS_LSB   = 22;
  localparam int unsigned RT_MSB   = 21;
  localparam int unsigned RT_LSB   = 17;

endpackage

// File: rtl/mem_wait_cnt.sv
// Load/decrement wait counter for BRAM read latency. done_o is high on the last wait cycle.
module mem_wait_cnt #(
  parameter int unsigned MemLat = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  localparam int unsigned   CntW    = $clog2(MemLat) + 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(MemLat - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mc_datapath_seq.sv
// Multi-cycle KGP-RISC datapath sequencer: owns PC/IR/ALU/MDR/store-data registers and the
// instruction-phase FSM, and drives the instruction and data BRAM ports.
module mc_datapath_seq
  import kgp_risc_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IMEM_AW  = 10,
  parameter int unsigned DMEM_AW  = 10,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        ir,
  output logic [4:0]         opcode,
  output logic [4:0]         funccode,
  input  logic               is_load,
  input  logic               is_store,
  input  logic               reg_write,
  input  logic               link,
  input  logic               is_halt,
  input  logic [XLEN-1:0]    alu_res,
  input  logic               br_taken,
  input  logic [XLEN-1:0]    br_target,
  input  logic [XLEN-1:0]    st_data,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  output logic               dmem_we,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               wb_en,
  output logic [XLEN-1:0]    wb_data,
  output logic [XLEN-1:0]    pc,
  output logic [2:0]         state,
  output logic               retire,
  output logic               halted
);

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [31:0]       ir_q;
  logic [XLEN-1:0]   alu_q;
  logic [XLEN-1:0]   mdr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              taken_q;
  logic [XLEN-1:0]   tgt_q;

  logic              cnt_load, cnt_dec, cnt_done;
  logic              mem_store;
  logic              retire_c;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   next_pc;
  state_e            ret_state;

  // Load together with store is treated as a plain load.
  assign mem_store = is_store & ~is_load;
  assign pc_plus4  = pc_q + XLEN'(4);
  assign ret_state = run ? StFetch : StIdle;

  // Instruction completes this cycle; EXEC decides from live decode, MEM/WB unconditionally.
  always_comb begin
    retire_c = 1'b0;
    case (state_q)
      StExec:  retire_c = ~(is_load | is_store) & ~reg_write;
      StMem:   retire_c = mem_store;
      StWb:    retire_c = 1'b1;
      default: retire_c = 1'b0;
    endcase
  end

  // Branch outcome is not latched yet when retiring straight out of EXEC, so use it live there.
  always_comb begin
    if (state_q == StExec) begin
      next_pc = br_taken ? br_target : pc_plus4;
    end else begin
      next_pc = taken_q ? tgt_q : pc_plus4;
    end
  end

  // FETCH and MEM never overlap, so one counter serves both; reload on any other state or retire.
  assign cnt_dec  = (state_q == StFetch) || (state_q == StMem);
  assign cnt_load = ~cnt_dec | retire_c;

  mem_wait_cnt #(
    .MemLat (MEM_LAT)
  ) u_wait_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .done_o (cnt_done)
  );

  // Instruction-phase FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= XLEN'(RESET_PC);
      ir_q    <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      wdata_q <= '0;
      taken_q <= 1'b0;
      tgt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (run) state_q <= StFetch;
        end
        StFetch: begin
          if (cnt_done) begin
            ir_q    <= imem_rdata;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          state_q <= is_halt ? StHalt : StExec;
        end
        StExec: begin
          alu_q   <= alu_res;
          wdata_q <= st_data;
          taken_q <= br_taken;
          tgt_q   <= br_target;
          if (is_load || is_store) begin
            state_q <= StMem;
          end else if (reg_write) begin
            state_q <= StWb;
          end else begin
            pc_q    <= next_pc;
            state_q <= ret_state;
          end
        end
        StMem: begin
          if (mem_store) begin
            pc_q    <= next_pc;
            state_q <= ret_state;
          end else if (cnt_done) begin
            mdr_q   <= dmem_rdata;
            state_q <= StWb;
          end
        end
        StWb: begin
          pc_q    <= next_pc;
          state_q <= ret_state;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Write-back source select.
  always_comb begin
    if (is_load) begin
      wb_data = mdr_q;
    end else if (link) begin
      wb_data = pc_plus4;
    end else begin
      wb_data = alu_q;
    end
  end

  // Strobes are gated by rst so nothing commits in a reset cycle.
  assign wb_en      = (state_q == StWb) & ~rst;
  assign dmem_we    = (state_q == StMem) & mem_store & ~rst;
  assign retire     = retire_c & ~rst;
  assign halted     = (state_q == StHalt);

  assign imem_addr  = pc_q[IMEM_AW+1:2];
  assign dmem_addr  = alu_q[DMEM_AW+1:2];
  assign dmem_wdata = wdata_q;
  assign ir         = ir_q;
  assign opcode     = ir_q[OPC_MSB:OPC_LSB];
  assign funccode   = ir_q[FUNC_MSB:FUNC_LSB];
  assign pc         = pc_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_datapath_seq.sv
// Scoreboard bench for mc_datapath_seq with MEM_LAT=3: directed instructions push expected
// write-backs, stores and retirements; a negedge monitor pops and compares them.
module tb_mc_datapath_seq;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata, ir;
  logic [4:0]  opcode, funccode;
  logic        is_load, is_store, reg_write, link, is_halt, br_taken;
  logic [31:0] alu_res, br_target, st_data;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata, wb_data, pc;
  logic        dmem_we, wb_en, retire, halted;
  logic [2:0]  state;

  logic [9:0]  dm_addr;
  logic [31:0] dm_data;

  always #5 clk = ~clk;

  // Instruction memory returns a word tagged with its own address; data memory holds one word.
  assign imem_rdata = {16'hC0DE, 6'd0, imem_addr};
  assign dmem_rdata = (dmem_addr == dm_addr) ? dm_data : 32'hBAD0_BAD0;

  mc_datapath_seq #(
    .XLEN     (32),
    .IMEM_AW  (10),
    .DMEM_AW  (10),
    .MEM_LAT  (L),
    .RESET_PC (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .opcode     (opcode),
    .funccode   (funccode),
    .is_load    (is_load),
    .is_store   (is_store),
    .reg_write  (reg_write),
    .link       (link),
    .is_halt    (is_halt),
    .alu_res    (alu_res),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .st_data    (st_data),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata),
    .wb_en      (wb_en),
    .wb_data    (wb_data),
    .pc         (pc),
    .state      (state),
    .retire     (retire),
    .halted     (halted)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    int          lat;
  } rt_t;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } st_t;

  rt_t         rt_q[$];
  st_t         st_q[$];
  logic [31:0] wb_q[$];

  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [31:0] exp_ir(input logic [31:0] p);
    return {16'hC0DE, 6'd0, p[11:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: got an unexpected pulse, want none", name);
  endtask

  function automatic void push_rt(input logic [31:0] p, input logic [31:0] np, input int lat);
    rt_t r;
    r.pc  = p;
    r.npc = np;
    r.lat = lat;
    rt_q.push_back(r);
  endfunction

  function automatic void push_st(input logic [9:0] a, input logic [31:0] d);
    st_t s;
    s.a = a;
    s.d = d;
    st_q.push_back(s);
  endfunction

  task automatic set_ctl(input bit ld, input bit st, input bit rw, input bit lk, input bit hl,
                         input bit tk, input logic [31:0] alu, input logic [31:0] tgt,
                         input logic [31:0] sd);
    is_load   = ld;
    is_store  = st;
    reg_write = rw;
    link      = lk;
    is_halt   = hl;
    br_taken  = tk;
    alu_res   = alu;
    br_target = tgt;
    st_data   = sd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_retire(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!retire && n < 60);
    check(name, 32'(retire), 32'd1);
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int n = 0;
    while (state !== s && n < 60) begin
      step();
      n++;
    end
    check(name, 32'(state), 32'(s));
  endtask

  // Monitor state.
  int          cyc = 0;
  int          fst = 0;
  logic [2:0]  prev_state = 3'd0;
  bit          pc_chk = 1'b0;
  logic [31:0] pc_exp = '0;
  logic [31:0] w_exp;
  rt_t         r_exp;
  st_t         s_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pc_chk = 1'b0;
      end else begin
        if (pc_chk) begin
          check("pc_after_retire", pc, pc_exp);
          pc_chk = 1'b0;
        end
        if (state == 3'd1 && prev_state != 3'd1) fst = cyc;
      end
      if (wb_en) begin
        if (wb_q.size() == 0) begin
          unexpected("wb_en");
        end else begin
          w_exp = wb_q.pop_front();
          check("wb_data", wb_data, w_exp);
          check("wb_with_retire", 32'(retire), 32'd1);
        end
      end
      if (dmem_we) begin
        if (st_q.size() == 0) begin
          unexpected("dmem_we");
        end else begin
          s_exp = st_q.pop_front();
          check("st_addr", 32'(dmem_addr), 32'(s_exp.a));
          check("st_wdata", dmem_wdata, s_exp.d);
        end
      end
      if (retire) begin
        if (rt_q.size() == 0) begin
          unexpected("retire");
        end else begin
          r_exp = rt_q.pop_front();
          check("retire_pc", pc, r_exp.pc);
          check("retire_ir", ir, exp_ir(r_exp.pc));
          check("latency", 32'(cyc - fst + 1), 32'(r_exp.lat));
          pc_exp = r_exp.npc;
          pc_chk = 1'b1;
        end
      end
      prev_state = state;
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    run     = 1'b0;
    dm_addr = '0;
    dm_data = '0;
    set_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_pc", pc, 32'd0);
    check("reset_ir", ir, 32'd0);
    check("reset_wdata", dmem_wdata, 32'd0);
    check("reset_strobes", 32'({dmem_we, wb_en, retire, halted}), 32'd0);
    check("reset_imem_addr", 32'(imem_addr), 32'd0);

    step();
    rst = 1'b0;
    run = 1'b1;

    // ALU op with write-back.
    set_ctl(0, 0, 1, 0, 0, 0, 32'h1234, 0, 0);
    wb_q.push_back(32'h1234);
    push_rt(32'h0, 32'h4, L + 3);
    wait_retire("retire_alu");
    step();

    // Store: one dmem_we pulse, no write-back.
    set_ctl(0, 1, 0, 0, 0, 0, 32'h20, 0, 32'hA5A5);
    push_st(10'd8, 32'hA5A5);
    push_rt(32'h4, 32'h8, L + 3);
    wait_retire("retire_store");
    step();

    // Load from word 0x10.
    dm_addr = 10'h10;
    dm_data = 32'hDEAD_BEEF;
    set_ctl(1, 0, 1, 0, 0, 0, 32'h40, 0, 0);
    wb_q.push_back(32'hDEAD_BEEF);
    push_rt(32'h8, 32'hC, 2 * L + 3);
    wait_retire("retire_load");
    step();

    // Taken branch without link retires from EXEC.
    set_ctl(0, 0, 0, 0, 0, 1, 32'h0, 32'h100, 0);
    push_rt(32'hC, 32'h100, L + 2);
    wait_retire("retire_branch");
    step();

    // Taken branch with link writes pc+4.
    set_ctl(0, 0, 1, 1, 0, 1, 32'h5555, 32'h200, 0);
    wb_q.push_back(32'h104);
    push_rt(32'h100, 32'h200, L + 3);
    wait_retire("retire_link");
    step();

    // ALU op without write-back.
    set_ctl(0, 0, 0, 0, 0, 0, 32'h77, 0, 0);
    push_rt(32'h200, 32'h204, L + 2);
    wait_retire("retire_nop");
    step();

    // Load and store both set: behaves as a load, no write strobe.
    dm_addr = 10'h11;
    dm_data = 32'h0BAD_F00D;
    set_ctl(1, 1, 1, 0, 0, 0, 32'h44, 0, 32'hFFFF);
    wb_q.push_back(32'h0BAD_F00D);
    push_rt(32'h204, 32'h208, 2 * L + 3);
    wait_retire("retire_ldst");
    step();

    // run dropped during a load: load finishes, then park in IDLE.
    dm_addr = 10'h12;
    dm_data = 32'h1357_2468;
    set_ctl(1, 0, 1, 0, 0, 0, 32'h48, 0, 0);
    wb_q.push_back(32'h1357_2468);
    push_rt(32'h208, 32'h20C, 2 * L + 3);
    wait_state(3'd4, "reach_mem");
    run = 1'b0;
    wait_retire("retire_drop");
    step();
    check("idle_after_drop", 32'(state), 32'd0);
    repeat (3) step();
    check("idle_parked", 32'(state), 32'd0);
    check("idle_pc", pc, 32'h20C);
    check("idle_imem_addr", 32'(imem_addr), 32'h83);
    run = 1'b1;
    set_ctl(0, 0, 1, 0, 0, 0, 32'h77, 0, 0);
    wb_q.push_back(32'h77);
    push_rt(32'h20C, 32'h210, L + 3);
    wait_retire("retire_resume");
    step();

    // Halt is sticky with pc frozen.
    set_ctl(0, 0, 0, 0, 1, 0, 0, 0, 0);
    begin
      int n = 0;
      while (!halted && n < 60) begin
        @(negedge clk);
        n++;
      end
    end
    check("halted", 32'(halted), 32'd1);
    check("halt_state", 32'(state), 32'd6);
    check("halt_pc", pc, 32'h210);
    check("halt_ir", ir, 32'hC0DE_0084);
    check("halt_opcode", 32'(opcode), 32'h18);
    check("halt_funccode", 32'(funccode), 32'h04);
    set_ctl(0, 0, 1, 0, 0, 1, 32'h99, 32'h300, 0);
    repeat (4) @(negedge clk);
    check("halt_sticky", 32'(halted), 32'd1);
    check("halt_pc_frozen", pc, 32'h210);

    // Reset during a store MEM cycle: no write, back to IDLE at RESET_PC.
    step();
    rst = 1'b1;
    run = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    run = 1'b1;
    set_ctl(0, 1, 0, 0, 0, 0, 32'h30, 0, 32'h99);
    wait_state(3'd4, "reach_store_mem");
    rst = 1'b1;
    #1;
    check("rst_no_we", 32'(dmem_we), 32'd0);
    check("rst_no_retire", 32'(retire), 32'd0);
    step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    run = 1'b0;
    rst = 1'b0;
    repeat (3) step();
    check("idle_no_run", 32'(state), 32'd0);
    check("idle_no_run_pc", pc, 32'd0);

    check("wb_q_empty", 32'(wb_q.size()), 32'd0);
    check("st_q_empty", 32'(st_q.size()), 32'd0);
    check("rt_q_empty", 32'(rt_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
